// File: rtl/result_writeback_pkg.sv
// Shared definitions for the result write-back slice: FSM state encoding,
// tile geometry constants, out_sel field layout and a priority helper.
package result_writeback_pkg;

  localparam int unsigned PE_DIM     = 4;
  localparam int unsigned TILE_WORDS = 64;

  // out_sel layout: PE row in [3:2], PE column in [1:0]
  localparam int unsigned SEL_ROW_MSB = 3;
  localparam int unsigned SEL_ROW_LSB = 2;
  localparam int unsigned SEL_COL_MSB = 1;
  localparam int unsigned SEL_COL_LSB = 0;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_SEL   = 6'b000010,
    ST_WAIT  = 6'b000100,
    ST_CAP   = 6'b001000,
    ST_WRITE = 6'b010000,
    ST_DONE  = 6'b100000
  } wb_state_e;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [1:0] first_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else if (m[3]) return 2'd3;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/result_writeback_addr_gen.sv
// wb_addr_gen: latches the tile geometry on load_i and combinationally
// produces the keep mask for PE position k_i and the memory word address of
// element (k_i, idx_i).
//   clk_i, rst_i      clock, synchronous active-high reset
//   load_i            latch geometry inputs
//   tile_row_i..base_addr_i  geometry to latch
//   k_i, idx_i        PE position and array index being addressed
//   keep_o            per-array in-range mask for position k_i
//   addr_o            base + row*cols + col (mod 2^ADDR_W)
module wb_addr_gen
  import result_writeback_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] tile_row_i,
  input  logic [ADDR_W-1:0] tile_col_i,
  input  logic [ADDR_W-1:0] out_rows_i,
  input  logic [ADDR_W-1:0] out_cols_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [3:0]        k_i,
  input  logic [1:0]        idx_i,
  output logic [3:0]        keep_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] tile_row_q, tile_col_q, out_rows_q, out_cols_q, base_q;
  logic [ADDR_W-1:0] row, col_base, col;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tile_row_q <= '0;
      tile_col_q <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      base_q     <= '0;
    end else if (load_i) begin
      tile_row_q <= tile_row_i;
      tile_col_q <= tile_col_i;
      out_rows_q <= out_rows_i;
      out_cols_q <= out_cols_i;
      base_q     <= base_addr_i;
    end
  end

  always_comb begin
    row      = tile_row_q + ADDR_W'(k_i[SEL_ROW_MSB:SEL_ROW_LSB]);
    col_base = tile_col_q + ADDR_W'({k_i[SEL_COL_MSB:SEL_COL_LSB], 2'b00});
    col      = col_base + ADDR_W'(idx_i);
    keep_o   = '0;
    for (int unsigned i = 0; i < PE_DIM; i++) begin
      keep_o[i] = (row < out_rows_q) && ((col_base + ADDR_W'(i)) < out_cols_q);
    end
    addr_o = base_q + row * out_cols_q + col;
  end

endmodule

// File: rtl/result_writeback.sv
// result_writeback: drains one 4x16 output tile from four PE arrays and
// writes the in-range elements to memory as 32-bit words.
//   clk, rst              clock, synchronous active-high reset
//   start                 launch pulse (IDLE only)
//   tile_row/tile_col     output coordinates of tile element (0,0)
//   out_rows/out_cols     output matrix size (out_cols is the row stride)
//   base_addr             word address of output element (0,0)
//   out_sel               PE position select to all arrays
//   result0..result3      result buses of the four arrays
//   mem_wvalid/mem_wready/mem_addr/mem_wdata  write channel
//   busy, done            status
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int unsigned NUM_ARRAYS = 4,
  parameter int unsigned SEL_LAT    = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] tile_row,
  input  logic [ADDR_W-1:0] tile_col,
  input  logic [ADDR_W-1:0] out_rows,
  input  logic [ADDR_W-1:0] out_cols,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [3:0]        out_sel,
  input  logic [31:0]       result0,
  input  logic [31:0]       result1,
  input  logic [31:0]       result2,
  input  logic [31:0]       result3,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done
);

  wb_state_e         state_q;
  logic [3:0]        out_sel_q;
  logic [1:0]        wait_q;
  logic [3:0]        keep_q;     // entries of the current position not yet written
  logic [1:0]        idx_q;      // entry currently presented on the write channel
  logic [31:0]       hold_q [NUM_ARRAYS];
  logic              mem_wvalid_q, busy_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic [31:0]       res [NUM_ARRAYS];
  logic [3:0]        rem_d;
  logic [1:0]        idx_d;
  logic [3:0]        ag_keep;
  logic [ADDR_W-1:0] ag_addr;
  logic              load;

  assign load = (state_q == ST_IDLE) && start;

  // The next entry is always the lowest remaining kept bit, so clipped
  // entries cost no cycles and the following write is set up in the same
  // edge that completes the current one.
  always_comb begin
    res[0] = result0;
    res[1] = result1;
    res[2] = result2;
    res[3] = result3;
    rem_d  = keep_q;
    if (mem_wvalid_q) rem_d[idx_q] = 1'b0;
    idx_d  = (state_q == ST_CAP) ? first_set(ag_keep) : first_set(rem_d);
  end

  wb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .tile_row_i  (tile_row),
    .tile_col_i  (tile_col),
    .out_rows_i  (out_rows),
    .out_cols_i  (out_cols),
    .base_addr_i (base_addr),
    .k_i         (out_sel_q),
    .idx_i       (idx_d),
    .keep_o      (ag_keep),
    .addr_o      (ag_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_sel_q    <= '0;
      wait_q       <= '0;
      keep_q       <= '0;
      idx_q        <= '0;
      mem_wvalid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_ARRAYS; i++) hold_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            out_sel_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SEL;
          end
        end
        ST_SEL: begin
          wait_q  <= '0;
          state_q <= (SEL_LAT == 0) ? ST_CAP : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == 2'(SEL_LAT - 1)) state_q <= ST_CAP;
          else                           wait_q  <= wait_q + 2'd1;
        end
        ST_CAP: begin
          for (int unsigned i = 0; i < NUM_ARRAYS; i++) hold_q[i] <= res[i];
          keep_q       <= ag_keep;
          idx_q        <= idx_d;
          mem_wvalid_q <= |ag_keep;
          mem_addr_q   <= ag_addr;
          mem_wdata_q  <= res[idx_d];   // hold_q is loading this same edge
          state_q      <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!(mem_wvalid_q && !mem_wready)) begin
            keep_q <= rem_d;
            idx_q  <= idx_d;
            if (|rem_d) begin
              mem_wvalid_q <= 1'b1;
              mem_addr_q   <= ag_addr;
              mem_wdata_q  <= hold_q[idx_d];
            end else begin
              mem_wvalid_q <= 1'b0;
              if (out_sel_q == 4'hF) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_DONE;
              end else begin
                out_sel_q <= out_sel_q + 4'd1;
                state_q   <= ST_SEL;
              end
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_sel    = out_sel_q;
  assign mem_wvalid = mem_wvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
